// File: rtl/dmem_if.sv
// dmem_if: MEM-stage data-memory bus (master = CPU datapath, slave = dmem_responder): request addr/wdata/mem_read/mem_write, response rdata/ready/stall/err
interface dmem_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;
  logic        err;
  modport master (output addr, wdata, mem_read, mem_write, input rdata, ready, stall, err);
  modport slave (input addr, wdata, mem_read, mem_write, output rdata, ready, stall, err);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: slow word-addressed data memory with LATENCY-cycle access, stall/ready/err handshake; ports clk, rst, bus (dmem_if.slave); option DMEM_ALIGN_CHECK_EN faults misaligned accesses
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr, r_wdata, r_rdata;
  logic          r_wr, r_ready, r_err;
  logic [31:0]   r_mem [DEPTH];
  logic          w_idle, w_req, w_hit, w_wr, w_fault;
  logic [31:0]   w_a, w_d;
  logic [AW-1:0] w_idx;
  // With LATENCY==1 the access edge is the acceptance edge, so the live bus is used instead of the latches
  always_comb begin
    w_idle  = r_state == IDLE;
    w_req   = bus.mem_read | bus.mem_write;
    w_hit   = w_idle ? (w_req && LATENCY == 1) : (r_state == BUSY && r_cnt == CW'(1));
    w_a     = w_idle ? bus.addr : r_addr;
    w_d     = w_idle ? bus.wdata : r_wdata;
    w_wr    = w_idle ? bus.mem_write : r_wr;
    w_fault = (|w_a[31:AW+2]) | (ALIGN & (|w_a[1:0]));
    w_idx   = w_a[AW+1:2];
  end
  assign bus.rdata = r_rdata;
  assign bus.ready = r_ready;
  assign bus.err   = r_err;
  assign bus.stall = (w_idle & w_req) | (r_state == BUSY);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_ready <= w_hit;
      r_err   <= w_hit & w_fault;
      if (w_hit && w_wr && !w_fault) r_mem[w_idx] <= w_d;
      if (w_hit && !w_wr) r_rdata <= w_fault ? '0 : r_mem[w_idx];
      case (r_state)
        IDLE: if (w_req) begin
          r_addr  <= bus.addr;
          r_wdata <= bus.wdata;
          r_wr    <= bus.mem_write;
          r_cnt   <= CW'(LATENCY - 1);
          r_state <= LATENCY == 1 ? DONE : BUSY;
        end
        BUSY: begin
          r_cnt   <= r_cnt - CW'(1);
          r_state <= r_cnt == CW'(1) ? DONE : BUSY;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a word-array reference model
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int LATENCY = 3;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata;
  dmem_if bus();
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_rdata = '0;
  endtask

  task automatic idle(input int n);
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      #1;
      chk("idle_stall", {31'b0, bus.stall}, 0);
      chk("idle_ready", {31'b0, bus.ready}, 0);
      chk("idle_err", {31'b0, bus.err}, 0);
      chk("idle_rdata", bus.rdata, model_rdata);
    end
  endtask

  // One full access: cycle 0 accept, BUSY cycles with scrambled inputs, then the DONE cycle
  task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    bit fault, is_wr;
    logic [31:0] prev;
    @(negedge clk);
    bus.addr = a;
    bus.wdata = d;
    bus.mem_read = rd;
    bus.mem_write = wr;
    #1;
    chk("acc_stall0", {31'b0, bus.stall}, 1);
    chk("acc_ready0", {31'b0, bus.ready}, 0);
    prev = model_rdata;
    fault = (a >= DEPTH * 4) || (ALIGN && (a % 4 != 0));
    is_wr = wr;
    if (is_wr && !fault) model_mem[(a / 4) % DEPTH] = d;
    if (!is_wr) model_rdata = fault ? '0 : model_mem[(a / 4) % DEPTH];
    for (int c = 1; c <= LATENCY; c++) begin
      @(negedge clk);
      bus.addr = $urandom;
      bus.wdata = $urandom;
      bus.mem_read = 1'($urandom);
      bus.mem_write = 1'($urandom);
      #1;
      if (c < LATENCY) begin
        chk("busy_stall", {31'b0, bus.stall}, 1);
        chk("busy_ready", {31'b0, bus.ready}, 0);
        chk("busy_rdata", bus.rdata, prev);
      end else begin
        chk("done_stall", {31'b0, bus.stall}, 0);
        chk("done_ready", {31'b0, bus.ready}, 1);
        chk("done_err", {31'b0, bus.err}, {31'b0, fault});
        chk("done_rdata", bus.rdata, model_rdata);
      end
    end
  endtask

  initial begin
    bus.addr = '0;
    bus.wdata = '0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(10);
    access(1, 0, 32'h10, 32'hDEADBEEF);
    access(0, 1, 32'h10, 32'h0);
    chk("rd_10", bus.rdata, 32'hDEADBEEF);
    idle(2);
    access(1, 1, 32'h20, 32'h12345678);
    access(0, 1, 32'h20, 32'h0);
    chk("rd_20", bus.rdata, 32'h12345678);
    access(1, 0, 32'h400, 32'hAAAA5555);
    access(0, 1, 32'h400, 32'h0);
    chk("rd_oor", bus.rdata, 32'h0);
    access(0, 1, 32'h0, 32'h0);
    chk("rd_0", bus.rdata, 32'h0);
    @(negedge clk);
    bus.addr = 32'h8;
    bus.wdata = 32'hCAFEF00D;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b1;
    @(negedge clk);
    bus.mem_write = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    model_reset();
    chk("rst_stall", {31'b0, bus.stall}, 0);
    chk("rst_ready", {31'b0, bus.ready}, 0);
    chk("rst_rdata", bus.rdata, 32'h0);
    rst = 1'b0;
    idle(1);
    access(0, 1, 32'h8, 32'h0);
    chk("rd_8", bus.rdata, 32'h0);
    access(1, 0, 32'h4, 32'h11111111);
    access(1, 0, 32'h5, 32'h22222222);
    access(0, 1, 32'h4, 32'h0);
    chk("rd_4", bus.rdata, ALIGN ? 32'h11111111 : 32'h22222222);
    for (int n = 0; n < 60; n++) begin
      bit wr, rd;
      logic [31:0] a;
      wr = 1'($urandom);
      rd = wr ? 1'($urandom) : 1'b1;
      a = ($urandom % 8 == 0) ? $urandom : 32'($urandom_range(0, 96));
      access(wr, rd, a, $urandom);
      if ($urandom % 4 == 0) idle(1);
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
